// File: rtl/cache_dm_pkg.sv
// -----------------------------------------------------------------------------
// cache_types : shared types and geometry defaults for the cache_dm block
// Revision    : 1.0
// -----------------------------------------------------------------------------
`default_nettype none

package cache_types;

  localparam int S_INDEX_DEF  = 3;
  localparam int S_OFFSET_DEF = 5;
  localparam int TAG_W_DEF    = 32 - S_INDEX_DEF - S_OFFSET_DEF;
  localparam int LINE_W       = 256;

  typedef logic [LINE_W-1:0] cache_line_t;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_CHECK     = 2'd1,
    ST_WRITEBACK = 2'd2,
    ST_ALLOCATE  = 2'd3
  } cache_state_t;

  // Expands a 4-lane word byte-enable into the 32-lane line byte-enable.
  function automatic logic [LINE_W/8-1:0] line_be(input logic [2:0] word,
                                                  input logic [3:0] be);
    line_be = (LINE_W/8)'(be) << {word, 2'b00};
  endfunction

endpackage

`default_nettype wire

// File: rtl/cache_array.sv
// -----------------------------------------------------------------------------
// cache_array : single-port register array, combinational read, optional
//               async clear and optional per-byte write enables
// Revision    : 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module cache_array #(
  parameter int WIDTH    = 1,
  parameter int DEPTH    = 8,
  parameter bit RESET_EN = 1'b0,
  parameter bit BYTE_EN  = 1'b0,
  parameter int AW       = $clog2(DEPTH),
  parameter int NBE      = BYTE_EN ? WIDTH / 8 : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [NBE-1:0]   be,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  generate
    if (BYTE_EN) begin : g_be
      always_comb begin
        mem_d = mem_q;
        if (we) begin
          for (int b = 0; b < NBE; b++) begin
            if (be[b]) mem_d[addr][b*8 +: 8] = wdata[b*8 +: 8];
          end
        end
      end
    end else begin : g_nobe
      logic unused_be;
      assign unused_be = ^be;
      always_comb begin
        mem_d = mem_q;
        if (we) mem_d[addr] = wdata;
      end
    end

    if (RESET_EN) begin : g_rst
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
          mem_q <= mem_d;
        end
      end
    end else begin : g_norst
      logic unused_rst;
      assign unused_rst = rst_n;
      always_ff @(posedge clk) begin
        mem_q <= mem_d;
      end
    end
  endgenerate

  assign rdata = mem_q[addr];

endmodule

`default_nettype wire

// File: rtl/cache_dm.sv
// -----------------------------------------------------------------------------
// cache_dm : direct-mapped write-back / write-allocate cache, 32-bit CPU port,
//            256-bit line burst memory port
// Revision : 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module cache_dm
  import cache_types::*;
#(
  parameter int S_INDEX  = S_INDEX_DEF,
  parameter int S_OFFSET = S_OFFSET_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [3:0]  mem_byte_enable,
  input  logic [31:0] mem_address,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_resp,
  output logic        pmem_read,
  output logic        pmem_write,
  output logic [31:0] pmem_address,
  output cache_line_t pmem_wdata,
  input  cache_line_t pmem_rdata,
  input  logic        pmem_resp
);

  localparam int TAG_W  = 32 - S_INDEX - S_OFFSET;
  localparam int SETS   = 1 << S_INDEX;
  localparam int WSEL_W = S_OFFSET - 2;

  cache_state_t state_q, state_d;
  logic [31:0]  addr_q, addr_d;
  logic [31:0]  wdata_q, wdata_d;
  logic [3:0]   be_q, be_d;
  logic         is_write_q, is_write_d;

  logic [S_INDEX-1:0] index;
  logic [TAG_W-1:0]   tag;
  logic [WSEL_W-1:0]  word_sel;
  logic [7:0]         word_lsb;

  logic               valid_rd, dirty_rd;
  logic [TAG_W-1:0]   tag_rd;
  cache_line_t        line_rd;
  logic               hit;

  logic               valid_we, dirty_we, dirty_wdata, tag_we, data_we;
  cache_line_t        data_wdata;
  logic [LINE_W/8-1:0] data_be;

  assign index    = addr_q[S_OFFSET +: S_INDEX];
  assign tag      = addr_q[31 -: TAG_W];
  assign word_sel = addr_q[2 +: WSEL_W];
  assign word_lsb = {word_sel, 5'b0};
  assign hit      = valid_rd && (tag_rd == tag);

  logic unused_addr;
  assign unused_addr = ^addr_q[1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      is_write_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      be_q       <= be_d;
      is_write_q <= is_write_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    be_d         = be_q;
    is_write_d   = is_write_q;
    mem_resp     = 1'b0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    valid_we     = 1'b0;
    dirty_we     = 1'b0;
    dirty_wdata  = 1'b0;
    tag_we       = 1'b0;
    data_we      = 1'b0;
    data_wdata   = '0;
    data_be      = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (mem_read || mem_write) begin
          addr_d     = mem_address;
          wdata_d    = mem_wdata;
          be_d       = mem_byte_enable;
          is_write_d = mem_write;
          state_d    = ST_CHECK;
        end
      end

      ST_CHECK: begin
        if (hit) begin
          mem_resp = 1'b1;
          // A zero byte-enable write still marks the line dirty.
          if (is_write_q) begin
            data_we     = 1'b1;
            data_wdata  = {(LINE_W/32){wdata_q}};
            data_be     = line_be(word_sel, be_q);
            dirty_we    = 1'b1;
            dirty_wdata = 1'b1;
          end
          state_d = ST_IDLE;
        end else if (valid_rd && dirty_rd) begin
          state_d = ST_WRITEBACK;
        end else begin
          state_d = ST_ALLOCATE;
        end
      end

      ST_WRITEBACK: begin
        pmem_write   = 1'b1;
        pmem_address = {tag_rd, index, {S_OFFSET{1'b0}}};
        pmem_wdata   = line_rd;
        if (pmem_resp) begin
          dirty_we = 1'b1;
          state_d  = ST_ALLOCATE;
        end
      end

      ST_ALLOCATE: begin
        pmem_read    = 1'b1;
        pmem_address = {tag, index, {S_OFFSET{1'b0}}};
        if (pmem_resp) begin
          data_we    = 1'b1;
          data_wdata = pmem_rdata;
          data_be    = '1;
          tag_we     = 1'b1;
          valid_we   = 1'b1;
          dirty_we   = 1'b1;
          state_d    = ST_CHECK;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // rdata is only meaningful during the response pulse; keep it quiet otherwise.
  assign mem_rdata = mem_resp ? line_rd[word_lsb +: 32] : 32'd0;

  cache_array #(.WIDTH(1), .DEPTH(SETS), .RESET_EN(1'b1), .BYTE_EN(1'b0)) u_valid (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (valid_we),
    .addr  (index),
    .wdata (1'b1),
    .be    (1'b1),
    .rdata (valid_rd)
  );

  cache_array #(.WIDTH(1), .DEPTH(SETS), .RESET_EN(1'b1), .BYTE_EN(1'b0)) u_dirty (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (dirty_we),
    .addr  (index),
    .wdata (dirty_wdata),
    .be    (1'b1),
    .rdata (dirty_rd)
  );

  cache_array #(.WIDTH(TAG_W), .DEPTH(SETS), .RESET_EN(1'b0), .BYTE_EN(1'b0)) u_tag (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (tag_we),
    .addr  (index),
    .wdata (tag),
    .be    (1'b1),
    .rdata (tag_rd)
  );

  cache_array #(.WIDTH(LINE_W), .DEPTH(SETS), .RESET_EN(1'b0), .BYTE_EN(1'b1)) u_data (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (data_we),
    .addr  (index),
    .wdata (data_wdata),
    .be    (data_be),
    .rdata (line_rd)
  );

endmodule

`default_nettype wire

// File: tb/tb_cache_dm.sv
// -----------------------------------------------------------------------------
// tb_cache_dm : scoreboard bench for cache_dm with a latency-programmable
//               line memory model
// Revision    : 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module tb_cache_dm;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         mem_read = 1'b0;
  logic         mem_write = 1'b0;
  logic [3:0]   mem_byte_enable = 4'h0;
  logic [31:0]  mem_address = 32'h0;
  logic [31:0]  mem_wdata = 32'h0;
  logic [31:0]  mem_rdata;
  logic         mem_resp;
  logic         pmem_read;
  logic         pmem_write;
  logic [31:0]  pmem_address;
  logic [255:0] pmem_wdata;
  logic [255:0] pmem_rdata;
  logic         pmem_resp;

  logic [255:0] m_rdata = '0;
  logic [255:0] inj_rdata = '0;
  logic         m_resp = 1'b0;
  logic         inj_resp = 1'b0;

  assign pmem_rdata = inj_resp ? inj_rdata : m_rdata;
  assign pmem_resp  = m_resp | inj_resp;

  always #5 clk = ~clk;

  cache_dm dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_byte_enable (mem_byte_enable),
    .mem_address     (mem_address),
    .mem_wdata       (mem_wdata),
    .mem_rdata       (mem_rdata),
    .mem_resp        (mem_resp),
    .pmem_read       (pmem_read),
    .pmem_write      (pmem_write),
    .pmem_address    (pmem_address),
    .pmem_wdata      (pmem_wdata),
    .pmem_rdata      (pmem_rdata),
    .pmem_resp       (pmem_resp)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  // Backing store contents and CPU-visible reference
  logic [31:0] bs      [int unsigned];
  logic [31:0] cpu_mem [int unsigned];

  function automatic logic [31:0] pat(input logic [31:0] a);
    if (a == 32'h0000_0104) return 32'hDEAD_BEEF;
    return {a[15:0] ^ 16'hA5C3, a[15:0]};
  endfunction

  function automatic logic [31:0] bs_word(input logic [31:0] a);
    if (bs.exists(a)) return bs[a];
    return pat(a);
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    if (cpu_mem.exists(a)) return cpu_mem[a];
    return bs_word(a);
  endfunction

  // Physical memory model
  int          pm_lat = 2;
  int          pm_cnt = 0;
  bit          pm_stall = 1'b0;
  int          rd_cnt = 0;
  int          wr_cnt = 0;
  int          overlap = 0;
  logic [31:0] last_rd_addr = '0;
  logic [31:0] last_wr_addr = '0;

  always @(negedge clk) begin
    m_resp = 1'b0;
    if (pmem_read && pmem_write) overlap++;
    if ((pmem_read || pmem_write) && !pm_stall) begin
      if (pm_cnt >= pm_lat) begin
        pm_cnt = 0;
        m_resp = 1'b1;
        if (pmem_write) begin
          for (int w = 0; w < 8; w++) bs[pmem_address + 32'(4*w)] = pmem_wdata[w*32 +: 32];
          wr_cnt++;
          last_wr_addr = pmem_address;
        end else begin
          for (int w = 0; w < 8; w++) m_rdata[w*32 +: 32] = bs_word(pmem_address + 32'(4*w));
          rd_cnt++;
          last_rd_addr = pmem_address;
        end
      end else begin
        pm_cnt++;
      end
    end else begin
      pm_cnt = 0;
    end
  end

  // Scoreboard
  typedef struct {
    bit          is_wr;
    logic [31:0] data;
    string       tag;
  } exp_t;

  exp_t exp_q[$];

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && mem_resp) begin
      if (exp_q.size() == 0) begin
        check_eq("resp_unexpected", {31'b0, mem_resp}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        if (!e.is_wr) check_eq(e.tag, mem_rdata, e.data);
      end
    end
  end

  task automatic do_req(input string tag, input bit rd, input bit wr,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] be, output int lat);
    exp_t        e;
    logic [31:0] merged;
    bit          got;
    if (wr) begin
      merged = ref_read(a);
      for (int b = 0; b < 4; b++) if (be[b]) merged[b*8 +: 8] = wd[b*8 +: 8];
      cpu_mem[a] = merged;
      e.is_wr = 1'b1;
      e.data  = '0;
    end else begin
      e.is_wr = 1'b0;
      e.data  = ref_read(a);
    end
    e.tag = tag;
    exp_q.push_back(e);
    @(negedge clk);
    mem_read        = rd;
    mem_write       = wr;
    mem_address     = a;
    mem_wdata       = wd;
    mem_byte_enable = be;
    lat = 0;
    got = 1'b0;
    while (!got && lat < 300) begin
      @(negedge clk);
      lat++;
      if (mem_resp) got = 1'b1;
    end
    mem_read  = 1'b0;
    mem_write = 1'b0;
    if (!got) begin
      check_eq({tag, "_timeout"}, {31'b0, got}, 32'd1);
      exp_q.delete();
    end
  endtask

  initial begin
    int lat;
    int rd0;
    int wr0;

    repeat (3) @(negedge clk);
    check_eq("rst_mem_resp",   {31'b0, mem_resp},   32'd0);
    check_eq("rst_pmem_read",  {31'b0, pmem_read},  32'd0);
    check_eq("rst_pmem_write", {31'b0, pmem_write}, 32'd0);
    check_eq("rst_pmem_addr",  pmem_address,        32'd0);
    rst_n = 1'b1;

    rd0 = rd_cnt; wr0 = wr_cnt;
    do_req("cold_rd", 1'b1, 1'b0, 32'h0000_0104, 32'h0, 4'h0, lat);
    check_eq("cold_fills",     32'(rd_cnt - rd0), 32'd1);
    check_eq("cold_wbs",       32'(wr_cnt - wr0), 32'd0);
    check_eq("cold_fill_addr", last_rd_addr,      32'h0000_0100);

    rd0 = rd_cnt;
    do_req("hit_rd", 1'b1, 1'b0, 32'h0000_0104, 32'h0, 4'h0, lat);
    check_eq("hit_lat",   32'(lat),          32'd1);
    check_eq("hit_fills", 32'(rd_cnt - rd0), 32'd0);

    do_req("hit_wr", 1'b0, 1'b1, 32'h0000_0104, 32'hAABB_CCDD, 4'b0101, lat);
    check_eq("hit_wr_lat", 32'(lat), 32'd1);
    do_req("rd_merged", 1'b1, 1'b0, 32'h0000_0104, 32'h0, 4'h0, lat);

    rd0 = rd_cnt; wr0 = wr_cnt;
    do_req("evict_rd", 1'b1, 1'b0, 32'h0000_1104, 32'h0, 4'h0, lat);
    check_eq("evict_wbs",       32'(wr_cnt - wr0),      32'd1);
    check_eq("evict_wb_addr",   last_wr_addr,           32'h0000_0100);
    check_eq("evict_wb_word1",  bs_word(32'h0000_0104), 32'hDEBB_BEDD);
    check_eq("evict_fills",     32'(rd_cnt - rd0),      32'd1);
    check_eq("evict_fill_addr", last_rd_addr,           32'h0000_1100);

    rd0 = rd_cnt; wr0 = wr_cnt;
    do_req("clean_rd", 1'b1, 1'b0, 32'h0000_2104, 32'h0, 4'h0, lat);
    check_eq("clean_wbs",   32'(wr_cnt - wr0), 32'd0);
    check_eq("clean_fills", 32'(rd_cnt - rd0), 32'd1);

    rd0 = rd_cnt;
    do_req("both_wr", 1'b1, 1'b1, 32'h0000_2104, 32'h1122_3344, 4'hF, lat);
    check_eq("both_lat",   32'(lat),          32'd1);
    check_eq("both_fills", 32'(rd_cnt - rd0), 32'd0);
    do_req("both_rd", 1'b1, 1'b0, 32'h0000_2104, 32'h0, 4'h0, lat);

    do_req("be0_wr", 1'b0, 1'b1, 32'h0000_2108, 32'hFFFF_FFFF, 4'h0, lat);
    do_req("be0_rd", 1'b1, 1'b0, 32'h0000_2108, 32'h0, 4'h0, lat);

    // Reset while a fill is outstanding
    pm_stall = 1'b1;
    @(negedge clk);
    mem_read    = 1'b1;
    mem_address = 32'h0000_3124;
    for (int i = 0; i < 20 && !pmem_read; i++) @(negedge clk);
    mem_read = 1'b0;
    check_eq("stall_fill_req", {31'b0, pmem_read}, 32'd1);
    #2 rst_n = 1'b0;
    #1 check_eq("rst_drop_read", {31'b0, pmem_read}, 32'd0);
    check_eq("rst_drop_addr", pmem_address, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cpu_mem.delete();
    @(negedge clk);
    inj_rdata = {8{32'hBAD0_BAD0}};
    inj_resp  = 1'b1;
    @(negedge clk);
    inj_resp = 1'b0;
    pm_stall = 1'b0;

    rd0 = rd_cnt;
    do_req("post_rst_rd", 1'b1, 1'b0, 32'h0000_3124, 32'h0, 4'h0, lat);
    check_eq("post_rst_fills", 32'(rd_cnt - rd0), 32'd1);

    rd0 = rd_cnt; wr0 = wr_cnt;
    do_req("post_rst_lost_wr", 1'b1, 1'b0, 32'h0000_2104, 32'h0, 4'h0, lat);
    check_eq("post_rst_wbs",   32'(wr_cnt - wr0), 32'd0);
    check_eq("post_rst_fills2", 32'(rd_cnt - rd0), 32'd1);

    repeat (3) @(negedge clk);
    check_eq("no_overlap", 32'(overlap),      32'd0);
    check_eq("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
